branch_resolve_unit: RTL

Registered branch-resolution stage for the RV32 pipeline. It sits at the EX/MEM boundary and classifies each resolved branch against its fetch-time prediction. It drives a one-cycle flush and redirect PC back to fetch. It also trains a parametrised table of saturating direction counters that fetch reads combinationally.

---
 rtl/branch_pkg.sv | 16 +
 rtl/branch_history_table.sv | 46 ++++
 rtl/branch_resolve_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared branch-resolution types: result encodings and direction-counter reset value.
package branch_pkg;

    typedef enum logic [1:0] {
        BR_WRONG_TGT = 2'b00,
        BR_CORRECT   = 2'b01,
        BR_RET_PC4   = 2'b10,
        BR_TAKE_ALU  = 2'b11
    } br_result_e;

    // Weakly-not-taken: one below the taken threshold, or 0 for single-bit counters.
    function automatic int unsigned cnt_reset_val(input int unsigned cnt_width);
        return (cnt_width <= 1) ? 32'd0 : (32'd1 << (cnt_width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Array of saturating direction counters with a combinational read port and one update port.
module branch_history_table
    import branch_pkg::*;
#(
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned CNT_WIDTH = 2,
    parameter int unsigned IDX       = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX-1:0]       rd_idx,
    output logic [CNT_WIDTH-1:0] rd_cnt,
    input  logic                 upd_en,
    input  logic [IDX-1:0]       upd_idx,
    input  logic                 upd_taken
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH-1:0] CntRst = CNT_WIDTH'(cnt_reset_val(CNT_WIDTH));

    logic [CNT_WIDTH-1:0] cnt_q [BHT_DEPTH];
    logic [CNT_WIDTH-1:0] upd_cur;
    logic [CNT_WIDTH-1:0] upd_next;

    // Read sees the registered value, so a same-cycle update is not visible yet.
    assign rd_cnt  = cnt_q[rd_idx];
    assign upd_cur = cnt_q[upd_idx];

    always_comb begin
        upd_next = upd_cur;
        if (upd_taken) begin
            if (upd_cur != CntMax) upd_next = upd_cur + CNT_WIDTH'(1);
        end else begin
            if (upd_cur != '0) upd_next = upd_cur - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) cnt_q[i] <= CntRst;
        end else if (upd_en) begin
            cnt_q[upd_idx] <= upd_next;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX/MEM branch resolution: classifies against prediction, flushes/redirects, trains the BHT.
// Perf counters are built only when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned WIDTH_DATA_LENGTH = 32,
    parameter int unsigned BHT_DEPTH         = 64,
    parameter int unsigned CNT_WIDTH         = 2,
    parameter int unsigned PERF_WIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         Resolve_Valid,
    input  logic                         Predicted,
    input  logic                         Execute,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_Pre,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_ALU,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_Branch,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_Plus4,
    input  logic [WIDTH_DATA_LENGTH-1:0] Lookup_PC,
    output logic                         Lookup_Taken,
    output logic                         Result_Valid,
    output logic [1:0]                   Result,
    output logic                         Flush,
    output logic [WIDTH_DATA_LENGTH-1:0] Redirect_PC,
    input  logic                         Perf_Clear,
    output logic [PERF_WIDTH-1:0]        Branch_Count,
    output logic [PERF_WIDTH-1:0]        Mispredict_Count
);

    localparam int unsigned IDX = $clog2(BHT_DEPTH);

    logic                         accept;
    logic                         mispredict;
    br_result_e                   result_d, result_q;
    logic [WIDTH_DATA_LENGTH-1:0] target_d;
    logic                         valid_q, flush_q;
    logic [WIDTH_DATA_LENGTH-1:0] redirect_q;
    logic [CNT_WIDTH-1:0]         lookup_cnt;
    logic                         pc_unused;

    // The resolve arriving alongside a flush is on the wrong path.
    assign accept     = Resolve_Valid && !flush_q;
    assign mispredict = (result_d != BR_CORRECT);

    always_comb begin
        result_d = BR_CORRECT;
        target_d = PC_Plus4;
        unique case ({Execute, Predicted})
            2'b00: begin result_d = BR_CORRECT;  target_d = PC_Plus4; end
            2'b01: begin result_d = BR_RET_PC4;  target_d = PC_Plus4; end
            2'b10: begin result_d = BR_TAKE_ALU; target_d = PC_ALU;   end
            2'b11: begin
                result_d = (PC_Pre == PC_ALU) ? BR_CORRECT : BR_WRONG_TGT;
                target_d = PC_ALU;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            result_q   <= BR_CORRECT;
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            valid_q <= accept;
            flush_q <= accept && mispredict;
            if (accept) result_q <= result_d;
            if (accept && mispredict) redirect_q <= target_d;
        end
    end

    assign Result_Valid = valid_q;
    assign Result       = result_q;
    assign Flush        = flush_q;
    assign Redirect_PC  = redirect_q;

    branch_history_table #(
        .BHT_DEPTH (BHT_DEPTH),
        .CNT_WIDTH (CNT_WIDTH),
        .IDX       (IDX)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (Lookup_PC[IDX+1:2]),
        .rd_cnt    (lookup_cnt),
        .upd_en    (accept),
        .upd_idx   (PC_Branch[IDX+1:2]),
        .upd_taken (Execute)
    );

    assign Lookup_Taken = lookup_cnt[CNT_WIDTH-1];
    assign pc_unused    = ^{Lookup_PC, PC_Branch};

`ifdef BRU_PERF_CNT_EN
    logic [PERF_WIDTH-1:0] branch_cnt_q, mispredict_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (Perf_Clear) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (accept && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + PERF_WIDTH'(1);
            if (accept && mispredict && mispredict_cnt_q != '1) begin
                mispredict_cnt_q <= mispredict_cnt_q + PERF_WIDTH'(1);
            end
        end
    end

    assign Branch_Count     = branch_cnt_q;
    assign Mispredict_Count = mispredict_cnt_q;
`else
    logic perf_unused;
    assign perf_unused      = Perf_Clear;
    assign Branch_Count     = '0;
    assign Mispredict_Count = '0;
`endif

endmodule
